// File: rtl/muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers, one bit per cycle plus a sign-fixup cycle.
// Optional macro MULDIV_DIV_EN builds the divide datapath; without it DIV/DIVU are accepted as one-cycle no-ops.
module muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_busy, r_done;
  logic                 w_done_nxt, w_load;
  logic [CW-1:0]        r_count;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opa, r_hi, r_lo;
  logic                 r_neg;

  logic                 w_sign_a, w_sign_b;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic [WIDTH:0]       w_madd;
  logic [2*WIDTH-1:0]   w_prod;

  assign w_sign_a = op[0] & a[WIDTH-1];
  assign w_sign_b = op[0] & b[WIDTH-1];
  assign w_abs_a  = w_sign_a ? -a : a;
  assign w_abs_b  = w_sign_b ? -b : b;

  // Multiply: upper half accumulates the multiplicand, the carry shifts back in as the multiplier shifts out.
  assign w_madd = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opa} : '0);
  assign w_prod = r_neg ? -r_acc : r_acc;

`ifdef MULDIV_DIV_EN
  logic                 r_is_div, r_neg_r;
  logic [WIDTH-1:0]     r_opb, r_rem;
  logic [WIDTH:0]       w_prem, w_diff;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_quo_fix, w_rem_fix;

  // The trial remainder is one bit wider than the divisor so the borrow is the sign of the subtraction.
  assign w_prem    = {r_rem, r_acc[WIDTH-1]};
  assign w_diff    = w_prem - {1'b0, r_opb};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_quo_fix = (r_opb == '0) ? '1 : (r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          w_state_nxt = S_CALC;
          w_load      = 1'b1;
`else
          if (op[1]) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_CALC;
            w_load      = 1'b1;
          end
`endif
        end
      end
      S_CALC: begin
        if (r_count == CW'(WIDTH - 1)) w_state_nxt = S_FIXUP;
      end
      S_FIXUP: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_acc   <= '0;
      r_opa   <= '0;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MULDIV_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opb    <= '0;
      r_rem    <= '0;
`endif
    end else begin
      if (!r_busy) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end

      if (w_load) begin
        r_count <= '0;
        r_neg   <= w_sign_a ^ w_sign_b;
        r_opa   <= w_abs_a;
`ifdef MULDIV_DIV_EN
        r_is_div <= op[1];
        r_neg_r  <= w_sign_a;
        r_opb    <= w_abs_b;
        r_rem    <= '0;
        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
`else
        r_acc    <= {{WIDTH{1'b0}}, w_abs_b};
`endif
      end else if (r_state == S_CALC) begin
        r_count <= r_count + CW'(1);
`ifdef MULDIV_DIV_EN
        if (r_is_div) begin
          r_rem              <= w_ge ? w_diff[WIDTH-1:0] : w_prem[WIDTH-1:0];
          r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_ge};
        end else begin
          r_acc <= {w_madd, r_acc[WIDTH-1:1]};
        end
`else
        r_acc <= {w_madd, r_acc[WIDTH-1:1]};
`endif
      end else if (r_state == S_FIXUP) begin
`ifdef MULDIV_DIV_EN
        if (r_is_div) begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end else begin
          r_hi <= w_prod[2*WIDTH-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
`else
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
`endif
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
